alu_mdu: RTL
============

Name: alu_mdu

Overview:
Parametrised execution unit for the integer core. It covers the base ALU operation set plus the RV32M multiply/divide group, selected by i_MdEn.
- Base ops and special-case divides complete one cycle after acceptance.
- Multiply and divide run on a shared iterative radix-2 datapath.
- Has a valid/busy handshake and a flush input so the pipeline can stall on it and kill it on redirect.

Parameters:
XLEN, 32, datapath width in bits; must be a power of 2, at least 8.
MUL_FAST, 0, 1 = multiply uses the single-cycle combinational product (latency 1); 0 = iterative shift-add.
SHW, $clog2(XLEN), shift-amount width. Derived; not overridden.

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_Valid  in  1  operation request
i_AluCtrl  in  4  base op code (ADD, SUB, AND, OR, XOR, SRL, SLL, SRA, BUF, SLT, SLTU); used when i_MdEn=0
i_MdEn  in  1  1 = M-extension op, selected by i_MdOp
i_MdOp  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_op1  in  XLEN  operand 1 (rs1 / dividend / multiplicand)
i_op2  in  XLEN  operand 2 (rs2 / divisor / multiplier)
i_Flush  in  1  abort in-flight op and drop any same-cycle request
o_Busy  out  1  combinational; high whenever state != IDLE
o_Valid  out  1  registered; one-cycle pulse, o_Result valid in that cycle
o_Result  out  XLEN  registered; holds last result until the next o_Valid

Behaviour:
- Reset (i_rstn=0, async): state=IDLE, o_Valid=0, o_Result=0, counter=0, o_Busy=0.
- Accept condition: i_Valid & !o_Busy & !i_Flush at a rising edge. A request while busy is ignored; the requester holds it.
- Base ops, latency 1: result registered at the accepting edge; o_Valid=1 in the next cycle.
  - Shifts use op2[SHW-1:0]. SRA is arithmetic.
  - SLT is a signed compare; SLTU is an unsigned compare. Both return a zero-extended 0/1.
  - BUF returns op2.
  - ADD/SUB wrap modulo 2^XLEN.
  - An undefined i_AluCtrl returns 0 with o_Valid still asserted.
- Division fast paths, latency 1, no iteration:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = op1.
  - Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV = op1, REM = 0.
- Iterative ops: MUL group when MUL_FAST=0; all non-special divides.
  - FSM states: IDLE -> ITER (exactly XLEN cycles, counter XLEN-1 down to 0) -> FIX (1 cycle) -> IDLE.
  - Operands are latched on acceptance.
  - Signed operands are converted to magnitudes at accept. The sign is corrected in FIX: quotient sign = s1^s2; remainder sign = s1; MULH/MULHSU product sign per operand signedness.
  - Multiply: 2*XLEN-bit product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Divide: restoring, one quotient bit per ITER cycle.
  - o_Result and o_Valid are registered at the FIX edge. o_Valid is high XLEN+2 cycles after acceptance.
  - o_Busy is high from the cycle after acceptance through the FIX cycle.
- MUL_FAST=1: MUL group takes the latency-1 path; the FSM is used only by divides.
- Flush: in ITER or FIX, the next edge returns to IDLE with no o_Valid, and o_Result is unchanged.
  - Flush with i_Valid in IDLE: the request is dropped.
  - Flush in the same cycle as a pending o_Valid pulse does not suppress that pulse; the pulse was already registered.
- Back-to-back: a new op may be accepted in the cycle o_Valid is high, since o_Busy=0 there.
- Reset asserted mid-ITER: immediate IDLE, with all outputs cleared asynchronously.

Decomposition:
- Shared package parameters.vh:
  - Existing base op codes.
  - New MD_MUL..MD_REMU funct3 constants.
  - FSM state encodings ST_IDLE, ST_ITER, ST_FIX.
- Sub-module mdu_serial_core: shift-add/restoring-subtract datapath, XLEN-parametrised, with start/step/done.
- alu_mdu holds the base-op mux, the fast paths, the FSM/counter and the sign fix.

Test Plan:
- Base op latency and SLTU: ADD 0x7FFFFFFF+1 -> o_Valid next cycle, 0x80000000; SLTU 0xFFFFFFFF,1 -> 0; SLT 0xFFFFFFFF,1 -> 1; SRA 0x80000000 by 35 -> 0xF0000000.
- Signed divide and remainder: DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; o_Valid exactly 34 cycles after accept; o_Busy high for 33 cycles.
- Division special cases: DIVU 5,0 -> 0xFFFFFFFF; REM 5,0 -> 5; DIV 0x80000000,0xFFFFFFFF -> 0x80000000 and REM -> 0, both with latency 1.
- Multiply high halves: MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; MULH -1,-1 -> 0; MULHSU -1,0xFFFFFFFF -> 0xFFFFFFFF; repeat with MUL_FAST=1 and check latency 1.
- Flush mid-operation: flush at ITER cycle 10 of DIVU -> no o_Valid, o_Busy low next cycle, o_Result keeps its prior value; a new ADD 2+3 accepted immediately -> 5.
- Reset mid-ITER, then XLEN=16 regression: deassert i_rstn during a MUL -> o_Valid=0, o_Result=0 asynchronously; XLEN=16 DIV 0x8000,0xFFFF -> 0x8000.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: operation encodings and FSM states shared by the execution unit
package alu_mdu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SRL,
        ALU_SLL, ALU_SRA, ALU_BUF, ALU_SLT, ALU_SLTU
    } alu_op_e;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;
    typedef enum logic [1:0] { ST_IDLE, ST_ITER, ST_FIX } state_e;
endpackage

// File: rtl/mdu_serial_core.sv
// mdu_serial_core: radix-2 shift-add multiplier / restoring divider, one bit per step
module mdu_serial_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic            div_q, ge;
    logic [XLEN-1:0] b_q, hi_q, lo_q, hi_d, lo_d, sub;
    logic [XLEN:0]   sum, shl;

    // hi:lo is the running product for multiply, remainder:quotient for divide
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign shl  = {hi_q, lo_q[XLEN-1]};
    assign ge   = shl >= {1'b0, b_q};
    assign sub  = shl[XLEN-1:0] - b_q;
    assign hi_d = div_q ? (ge ? sub : shl[XLEN-1:0]) : sum[XLEN:1];
    assign lo_d = div_q ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
    assign hi_o = hi_q;
    assign lo_o = lo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= 1'b0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (start_i) begin
            div_q <= div_i;
            b_q   <= b_i;
            hi_q  <= '0;
            lo_q  <= a_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: base ALU plus RV32M multiply/divide on a shared iterative datapath
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0,
    localparam int SHW     = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_Valid,
    input  logic [3:0]      i_AluCtrl,
    input  logic            i_MdEn,
    input  logic [2:0]      i_MdOp,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_Flush,
    output logic            o_Busy,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_Result
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q;
    md_op_e            op_q;
    logic [SHW-1:0]    cnt_q;
    logic              neg_q, valid_q, neg_d;
    logic [XLEN-1:0]   result_q;
    logic              accept, is_div, sgn1, sgn2, neg1, neg2, by_zero, ovf, iter;
    logic [XLEN-1:0]   mag1, mag2, alu_res, quick_res, fix_val, fix_res, hi, lo;
    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] fast_prod, ser_prod;

    assign o_Busy   = state_q != ST_IDLE;
    assign o_Valid  = valid_q;
    assign o_Result = result_q;
    assign accept   = i_Valid & ~o_Busy & ~i_Flush;
    assign is_div   = i_MdOp[2];
    assign sgn1     = md_op_e'(i_MdOp) inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign sgn2     = md_op_e'(i_MdOp) inside {MD_MULH, MD_DIV, MD_REM};
    assign neg1     = sgn1 & i_op1[XLEN-1];
    assign neg2     = sgn2 & i_op2[XLEN-1];
    assign mag1     = neg1 ? -i_op1 : i_op1;
    assign mag2     = neg2 ? -i_op2 : i_op2;
    assign by_zero  = i_op2 == '0;
    assign ovf      = sgn2 & (i_op1 == MIN_NEG) & (&i_op2);
    assign iter     = i_MdEn & (is_div ? ~(by_zero | ovf) : ~MUL_FAST);
    // remainders take the dividend's sign only; everything else takes s1^s2
    assign neg_d    = neg1 ^ (neg2 & ~(is_div & i_MdOp[1]));
    assign shamt    = i_op2[SHW-1:0];

    always_comb begin
        case (alu_op_e'(i_AluCtrl))
            ALU_ADD:  alu_res = i_op1 + i_op2;
            ALU_SUB:  alu_res = i_op1 - i_op2;
            ALU_AND:  alu_res = i_op1 & i_op2;
            ALU_OR:   alu_res = i_op1 | i_op2;
            ALU_XOR:  alu_res = i_op1 ^ i_op2;
            ALU_SRL:  alu_res = i_op1 >> shamt;
            ALU_SLL:  alu_res = i_op1 << shamt;
            ALU_SRA:  alu_res = $signed(i_op1) >>> shamt;
            ALU_BUF:  alu_res = i_op2;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_op1) < $signed(i_op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, i_op1 < i_op2};
            default:  alu_res = '0;
        endcase
    end

    assign fast_prod = {{XLEN{neg1}}, i_op1} * {{XLEN{neg2}}, i_op2};
    assign quick_res = !i_MdEn ? alu_res
                     : is_div  ? (i_MdOp[1] ? (by_zero ? i_op1 : '0) : (by_zero ? '1 : i_op1))
                     : (i_MdOp == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];

    assign ser_prod = neg_q ? -{hi, lo} : {hi, lo};
    assign fix_val  = op_q[1] ? hi : lo;
    assign fix_res  = op_q[2] ? (neg_q ? -fix_val : fix_val)
                    : (op_q == MD_MUL) ? ser_prod[XLEN-1:0] : ser_prod[2*XLEN-1:XLEN];

    mdu_serial_core #(.XLEN(XLEN)) u_core (
        .clk_i  (i_clk),
        .rst_ni (i_rstn),
        .start_i(accept & iter),
        .step_i (state_q == ST_ITER),
        .div_i  (is_div),
        .a_i    (mag1),
        .b_i    (mag2),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && iter) begin
                        state_q <= ST_ITER;
                        op_q    <= md_op_e'(i_MdOp);
                        cnt_q   <= SHW'(XLEN - 1);
                        neg_q   <= neg_d;
                    end else if (accept) begin
                        valid_q  <= 1'b1;
                        result_q <= quick_res;
                    end
                end
                ST_ITER: begin
                    if (i_Flush)
                        state_q <= ST_IDLE;
                    else if (cnt_q == '0)
                        state_q <= ST_FIX;
                    cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    valid_q <= ~i_Flush;
                    if (!i_Flush)
                        result_q <= fix_res;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
